pipe_dest_tracker: RTL

//   Producer side of the hazard/forwarding interface. Carries each decoded instruction's

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/pipe_dest_tracker_if.sv | 38 +++
 rtl/pipe_dest_stage.sv | 31 +++
 rtl/pipe_dest_tracker.sv | 100 ++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline destination-tag tracker.
// Holds the stage-tag record {rd, rf_en, load}, the bubble constant and the
// helper that builds a tag from decoded ID fields.
package pipe_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

   // One pipeline stage's destination record.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic                  rf_en;
      logic                  load;
   } dest_tag_t;

   // A bubble carries no destination and never enables forwarding or a load stall.
   localparam dest_tag_t BUBBLE = '{rd: ZERO_REG, rf_en: 1'b0, load: 1'b0};

   // Writes to r0 are architecturally discarded, so they must never look like a
   // forwarding source. The load flag is kept as-is so load-use stalls stay conservative.
   function automatic dest_tag_t make_tag(input logic [REG_ADDR_W-1:0] rd,
                                          input logic                  rf_en,
                                          input logic                  load);
      dest_tag_t t;
      t.rd    = rd;
      t.rf_en = rf_en & (rd != ZERO_REG);
      t.load  = load;
      return t;
   endfunction

endpackage

// File: rtl/pipe_dest_tracker_if.sv
// Bundle of ID-side inputs, hazard-unit controls and the stage-tag outputs of
// pipe_dest_tracker. The master side drives ID/control; the slave is the tracker.
interface pipe_dest_tracker_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
);
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  id_rf_enable;
   logic                  id_load_instr;
   logic                  control_select;
   logic                  flush;
   logic                  mem_stall;

   logic [REG_ADDR_W-1:0] rd_ex;
   logic [REG_ADDR_W-1:0] rd_mem;
   logic [REG_ADDR_W-1:0] rd_wb;
   logic                  EX_RF_Enable;
   logic                  MEM_RF_Enable;
   logic                  WB_RF_Enable;
   logic                  EX_load_instr;
   logic                  wb_commit;
   logic [CNT_W-1:0]      bubble_count;

   modport master (
      output id_valid, id_rd, id_rf_enable, id_load_instr,
             control_select, flush, mem_stall,
      input  rd_ex, rd_mem, rd_wb, EX_RF_Enable, MEM_RF_Enable, WB_RF_Enable,
             EX_load_instr, wb_commit, bubble_count
   );

   modport slave (
      input  id_valid, id_rd, id_rf_enable, id_load_instr,
             control_select, flush, mem_stall,
      output rd_ex, rd_mem, rd_wb, EX_RF_Enable, MEM_RF_Enable, WB_RF_Enable,
             EX_load_instr, wb_commit, bubble_count
   );
endinterface

// File: rtl/pipe_dest_stage.sv
// One pipeline stage register holding a destination tag.
// hold_i freezes the stage; squash_i (only meaningful while held) clears the
// write-enable and load flag in place while keeping the rd tag.
module pipe_dest_stage
   import pipe_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      hold_i,
   input  logic      squash_i,
   input  dest_tag_t tag_i,
   output dest_tag_t tag_o
);

   dest_tag_t tag_q;

   // Load a new tag when advancing; when frozen, optionally kill it in place.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q <= BUBBLE;
      end else if (!hold_i) begin
         tag_q <= tag_i;
      end else if (squash_i) begin
         tag_q.rf_en <= 1'b0;
         tag_q.load  <= 1'b0;
      end
   end

   assign tag_o = tag_q;

endmodule

// File: rtl/pipe_dest_tracker.sv
// Producer side of the hazard/forwarding interface: carries each ID instruction's
// destination tag through EX, MEM and WB and publishes the per-stage tags.
// Optional feature macro: PDT_BUBBLE_CNT_EN enables the saturating bubble counter;
// without it bubble_count is tied to zero.
module pipe_dest_tracker
   import pipe_pkg::*;
#(
   parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
   parameter int CNT_W      = 16
) (
   input logic                clk,
   input logic                rst_n,
   pipe_dest_tracker_if.slave bus
);

   localparam int N_STAGES = 3;   // 0 = EX, 1 = MEM, 2 = WB

   logic                  advance;
   logic                  ex_bubble;
   logic [REG_ADDR_W-1:0] id_rd_w;
   dest_tag_t             tag_d    [N_STAGES];
   dest_tag_t             tag_q    [N_STAGES];
   logic                  squash_w [N_STAGES];
   logic                  wb_commit_q;
   logic                  unused_wb_load;

   assign advance   = !bus.mem_stall;
   assign ex_bubble = bus.flush | bus.control_select | !bus.id_valid;
   assign id_rd_w   = bus.id_rd;

   // Next-state tags: ID feeds EX (or a bubble), EX feeds MEM without its load flag,
   // MEM feeds WB unchanged.
   always_comb begin
      tag_d[0]      = ex_bubble ? BUBBLE
                                : make_tag(id_rd_w, bus.id_rf_enable, bus.id_load_instr);
      tag_d[1]      = tag_q[0];
      tag_d[1].load = 1'b0;
      tag_d[2]      = tag_q[1];
   end

   // A flush that arrives while frozen can only kill the instruction sitting in EX.
   always_comb begin
      squash_w[0] = bus.flush;
      squash_w[1] = 1'b0;
      squash_w[2] = 1'b0;
   end

   generate
      for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
         pipe_dest_stage u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .hold_i   (bus.mem_stall),
            .squash_i (squash_w[gi]),
            .tag_i    (tag_d[gi]),
            .tag_o    (tag_q[gi])
         );
      end
   endgenerate

   // Pulse once when a writing instruction moves from MEM into WB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_commit_q <= 1'b0;
      end else begin
         wb_commit_q <= advance & tag_q[1].rf_en;
      end
   end

`ifdef PDT_BUBBLE_CNT_EN
   logic [CNT_W-1:0] bubble_cnt_q;

   // Count hazard-requested bubbles on advancing edges; a flush wins, and the count sticks at max.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt_q <= '0;
      end else if (advance && bus.control_select && !bus.flush
                   && (bubble_cnt_q != {CNT_W{1'b1}})) begin
         bubble_cnt_q <= bubble_cnt_q + 1'b1;
      end
   end

   assign bus.bubble_count = bubble_cnt_q;
`else
   assign bus.bubble_count = {CNT_W{1'b0}};
`endif

   assign bus.rd_ex         = tag_q[0].rd;
   assign bus.rd_mem        = tag_q[1].rd;
   assign bus.rd_wb         = tag_q[2].rd;
   assign bus.EX_RF_Enable  = tag_q[0].rf_en;
   assign bus.MEM_RF_Enable = tag_q[1].rf_en;
   assign bus.WB_RF_Enable  = tag_q[2].rf_en;
   assign bus.EX_load_instr = tag_q[0].load;
   assign bus.wb_commit     = wb_commit_q;

   // The WB load flag is always zero by construction and has no consumer.
   assign unused_wb_load = tag_q[2].load;

endmodule
